alu_32bit: RTL and testbench
============================

# alu_32bit

Registered 32-bit integer ALU for the execute stage of the DLX pipeline. It computes one of a fixed set of logic, arithmetic, shift and compare operations on two 32-bit operands. It registers the result together with Carryout, Overflow, Zero and Set status flags. Forwarding and branch logic downstream consume these outputs one cycle after issue.

## Interface
- Clock is `clk`; reset is `rst`. One clock; reset is synchronous and active-high.
- No parameters. Data width is fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- Valid  in  1  operand/opcode qualifier; when high, the ALU captures a new result
- A  in  32  operand A
- B  in  32  operand B; B[4:0] is the shift amount for shifts
- Op  in  4  opcode
- Result  out  32  registered result
- Carryout  out  1  registered carry / no-borrow
- Overflow  out  1  registered signed overflow
- Zero  out  1  registered (Result == 0)
- Set  out  1  registered compare outcome
- Done  out  1  high for the one cycle after an accepted Valid

## Operation
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 SUB (A−B)
  - 4 XOR
  - 5 SLL (A << B[4:0])
  - 6 SRL, logical (A >> B[4:0])
  - 7 SLTU (unsigned A<B)
  - 8 SLT (signed A<B)
  - 9 SGE (signed A>=B)
  - 10 SRA
  - 11 SEQ
  - 12 SNE
  - 13–15 reserved: Result=0, all flags 0 except Zero=1.
- ADD:
  - Carryout = carry out of bit 31.
  - Overflow = operands share a sign and the sign of the sum differs from it.
- SUB is computed as A + ~B + 1:
  - Carryout = carry out of bit 31, i.e. 1 when A >= B unsigned.
  - Overflow = A and B have different signs and the sign of the difference differs from A's.
- All other opcodes: Carryout=0, Overflow=0.
- Compares (7, 8, 9, 11, 12): Result = {31'b0, c}, where c is the compare outcome; Set = c.
- Non-compare opcodes: Set = 0.
- Shift amounts are 0–31. Shift by 0 passes A unchanged.
- Zero is computed from the final 32-bit Result for every opcode.
- Shifts and SRA never set Carryout.

## Timing
- One-cycle latency.
  - Inputs are sampled on the rising clk edge when Valid=1.
  - Result, the flags and Done=1 are visible after that edge.
- Valid=0 at an edge: Result and the flags hold their previous values; Done=0.
- Back-to-back Valid is accepted every cycle with full throughput and no stall.
- rst=1 at an edge clears Result to 0, Carryout, Overflow, Set and Done to 0, and sets Zero to 1.
  - This is consistent with Result=0.
  - Reset overrides a simultaneous Valid; that operation is discarded.
- Reset asserted mid-stream: the next edge clears the outputs regardless of in-flight data; there is no partial state.

## Configuration
- `ALU_EXT_OPS_EN`
  - Defined: opcodes 10 (SRA), 11 (SEQ) and 12 (SNE) are implemented as above.
  - Undefined: opcodes 10–12 behave as reserved (Result=0, Zero=1, other flags 0), and the SRA/equality logic is not synthesized.

## Structure
- Shared package `alu_pkg` holds:
  - the 4-bit opcode enum `alu_op_t` with all 16 codes named
  - the `ALU_W = 32` constant
- One sub-module, `alu_addsub`: a 32-bit adder/subtractor producing sum, carry-out and overflow, with a sub-select input.
  - SUB, SLT, SLTU, SGE, SEQ and SNE all reuse its result.
  - SLT: overflow XOR sign of the difference.
  - SLTU: NOT carry.
  - SGE: NOT SLT.
  - SEQ/SNE: zero-detect on the difference.
- The top level holds the opcode mux, the shifter and the output registers.

## Test plan
- Logic ops, each issued with Valid and checked one cycle later:
  - AND 7,5 → Result 5
  - OR 1,4 → Result 5
  - XOR 13,7 → Result 0xA
- Shifts:
  - SLL 1023,2 → 0xFFC
  - SRL 1023,2 → 0xFF
  - SLL 1,31 → 0x80000000
  - SRL 0x80000000,31 → 1
- Arithmetic:
  - SUB 5,4 → Result 1, Carryout 1, Overflow 0
  - SUB −5,−70 → Result 65, Carryout 1
  - ADD −45,−20 → 0xFFFFFFBF, Carryout 1, Overflow 0
- Flag edge cases:
  - ADD 100, 0x7FFFFFFD → 0x80000061, Overflow 1, Carryout 0
  - ADD −1,1 → Result 0, Zero 1, Carryout 1, Overflow 0
- Compares:
  - SLT −15,−7 → Result 1, Set 1
  - SLTU 1024,2133 → 1
  - SGE 3024,2133 → 1
  - SLTU 0xFFFFFFFF,1 → 0, Set 0
- Control:
  - Valid=0 holds the prior Result.
  - rst=1 concurrent with Valid gives Result 0, Zero 1, Done 0.
  - Opcode 14 gives Result 0, Zero 1.
  - With `ALU_EXT_OPS_EN`: SRA 0x80000000,4 → 0xF8000000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the DLX execute-stage ALU.
// Opcodes 10-12 are only implemented when ALU_EXT_OPS_EN is defined.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SLTU  = 4'd7,
      OP_SLT   = 4'd8,
      OP_SGE   = 4'd9,
      OP_SRA   = 4'd10,
      OP_SEQ   = 4'd11,
      OP_SNE   = 4'd12,
      OP_RSV13 = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// 32-bit adder/subtractor; subtraction is a + ~b + 1 so carry means "no borrow".
module alu_addsub
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic             sub,
   output logic [ALU_W-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [ALU_W-1:0] b_eff_s;

   assign b_eff_s = sub ? ~b : b;
   assign {carry, sum} = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, sub};
   // Same-sign addends producing a sum of the other sign
   assign overflow = (a[ALU_W-1] == b_eff_s[ALU_W-1]) & (sum[ALU_W-1] != a[ALU_W-1]);

endmodule

// File: rtl/alu_32bit.sv
// Registered 32-bit ALU: opcode mux, shifter and output registers.
// Define ALU_EXT_OPS_EN to implement SRA, SEQ and SNE (otherwise reserved).
module alu_32bit
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             Valid,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] B,
   input  logic [3:0]       Op,
   output logic [ALU_W-1:0] Result,
   output logic             Carryout,
   output logic             Overflow,
   output logic             Zero,
   output logic             Set,
   output logic             Done
);

   alu_op_t          op_s;
   logic             sub_s;
   logic [ALU_W-1:0] sum_s;
   logic             carry_s;
   logic             ovf_s;
   logic             slt_s;
   logic             sltu_s;
   logic [ALU_W-1:0] res_s;
   logic             cout_s;
   logic             vflag_s;
   logic             cmp_s;
   logic             zero_s;

   logic [ALU_W-1:0] result_r;
   logic             carry_r;
   logic             ovf_r;
   logic             zero_r;
   logic             set_r;
   logic             done_r;

   assign op_s  = alu_op_t'(Op);
   assign sub_s = (op_s != OP_ADD);

   alu_addsub u_addsub (
      .a        (A),
      .b        (B),
      .sub      (sub_s),
      .sum      (sum_s),
      .carry    (carry_s),
      .overflow (ovf_s)
   );

   assign slt_s  = ovf_s ^ sum_s[ALU_W-1];
   assign sltu_s = ~carry_s;

`ifdef ALU_EXT_OPS_EN
   logic             eq_s;
   logic [ALU_W-1:0] sra_s;

   assign eq_s  = (sum_s == 32'd0);
   assign sra_s = $unsigned($signed(A) >>> B[4:0]);
`endif

   // Opcode mux selecting result and status flags
   always_comb begin
      res_s   = 32'd0;
      cout_s  = 1'b0;
      vflag_s = 1'b0;
      cmp_s   = 1'b0;
      case (op_s)
         OP_AND:  res_s = A & B;
         OP_OR:   res_s = A | B;
         OP_XOR:  res_s = A ^ B;
         OP_ADD, OP_SUB: begin
            res_s   = sum_s;
            cout_s  = carry_s;
            vflag_s = ovf_s;
         end
         OP_SLL:  res_s = A << B[4:0];
         OP_SRL:  res_s = A >> B[4:0];
         OP_SLTU: begin
            cmp_s = sltu_s;
            res_s = {31'd0, sltu_s};
         end
         OP_SLT: begin
            cmp_s = slt_s;
            res_s = {31'd0, slt_s};
         end
         OP_SGE: begin
            cmp_s = ~slt_s;
            res_s = {31'd0, ~slt_s};
         end
`ifdef ALU_EXT_OPS_EN
         OP_SRA:  res_s = sra_s;
         OP_SEQ: begin
            cmp_s = eq_s;
            res_s = {31'd0, eq_s};
         end
         OP_SNE: begin
            cmp_s = ~eq_s;
            res_s = {31'd0, ~eq_s};
         end
`endif
         default: res_s = 32'd0;
      endcase
   end

   assign zero_s = (res_s == 32'd0);

   // Output registers: reset wins, Valid captures, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r <= 32'd0;
         carry_r  <= 1'b0;
         ovf_r    <= 1'b0;
         zero_r   <= 1'b1;
         set_r    <= 1'b0;
         done_r   <= 1'b0;
      end else if (Valid) begin
         result_r <= res_s;
         carry_r  <= cout_s;
         ovf_r    <= vflag_s;
         zero_r   <= zero_s;
         set_r    <= cmp_s;
         done_r   <= 1'b1;
      end else begin
         done_r   <= 1'b0;
      end
   end

   assign Result   = result_r;
   assign Carryout = carry_r;
   assign Overflow = ovf_r;
   assign Zero     = zero_r;
   assign Set      = set_r;
   assign Done     = done_r;

endmodule

// File: tb/tb_alu_32bit.sv
// Scoreboard bench for alu_32bit: a behavioural model queues expected outputs at issue,
// a negedge monitor pops and compares them when Done is seen, and checks hold/reset states.
module tb_alu_32bit;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        s;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Valid = 1'b0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic [3:0]  Op = 4'd0;
   logic [31:0] Result;
   logic        Carryout, Overflow, Zero, Set, Done;

   exp_t sb_q[$];
   exp_t last_exp;
   exp_t rst_exp = '{res: 32'd0, c: 1'b0, v: 1'b0, z: 1'b1, s: 1'b0};
   logic rst_seen = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_32bit dut (
      .clk(clk), .rst(rst), .Valid(Valid), .A(A), .B(B), .Op(Op),
      .Result(Result), .Carryout(Carryout), .Overflow(Overflow),
      .Zero(Zero), .Set(Set), .Done(Done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check_val({tag, ".result"},   Result,   e.res);
      check_val({tag, ".carryout"}, Carryout, e.c);
      check_val({tag, ".overflow"}, Overflow, e.v);
      check_val({tag, ".zero"},     Zero,     e.z);
      check_val({tag, ".set"},      Set,      e.s);
   endtask

   // Reference model using wide signed arithmetic
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t              e;
      longint            sa, sb, sr;
      logic [32:0]       w;
      logic signed [31:0] as32;
      e    = '0;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      as32 = a;
      case (op)
         4'd0: e.res = a & b;
         4'd1: e.res = a | b;
         4'd2: begin
            w = {1'b0, a} + {1'b0, b};
            e.res = w[31:0];
            e.c = w[32];
            sr = sa + sb;
            e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd3: begin
            e.res = a - b;
            e.c = (a >= b);
            sr = sa - sb;
            e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd4: e.res = a ^ b;
         4'd5: e.res = a << b[4:0];
         4'd6: e.res = a >> b[4:0];
         4'd7: begin e.s = (a < b);   e.res = {31'd0, e.s}; end
         4'd8: begin e.s = (sa < sb);  e.res = {31'd0, e.s}; end
         4'd9: begin e.s = (sa >= sb); e.res = {31'd0, e.s}; end
`ifdef ALU_EXT_OPS_EN
         4'd10: e.res = as32 >>> b[4:0];
         4'd11: begin e.s = (a == b); e.res = {31'd0, e.s}; end
         4'd12: begin e.s = (a != b); e.res = {31'd0, e.s}; end
`endif
         default: e.res = 32'd0;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      rst = 1'b0; Valid = 1'b1; Op = op; A = a; B = b;
      sb_q.push_back(model(op, a, b));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0; Valid = 1'b0; A = $urandom; B = $urandom; Op = 4'($urandom_range(15));
      end
   endtask

   task automatic reset_with_valid();
      @(negedge clk);
      rst = 1'b1; Valid = 1'b1; Op = 4'd2; A = 32'd7; B = 32'd9;
   endtask

   always @(posedge clk) rst_seen <= rst;

   // Monitor: reset state, scoreboard pop on Done, otherwise outputs must hold
   always @(negedge clk) begin
      exp_t e;
      if (rst_seen) begin
         check_val("reset.done", Done, 1'b0);
         check_all("reset", rst_exp);
         last_exp = rst_exp;
      end else if (Done) begin
         check_val("sb_nonempty", (sb_q.size() != 0), 1'b1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_all("op", e);
            last_exp = e;
         end
      end else begin
         check_all("hold", last_exp);
      end
   end

   initial begin
      logic [31:0] ra, rb;
      repeat (2) @(negedge clk);
      issue(4'd0, 32'd7, 32'd5);
      issue(4'd1, 32'd1, 32'd4);
      issue(4'd4, 32'd13, 32'd7);
      issue(4'd5, 32'd1023, 32'd2);
      issue(4'd6, 32'd1023, 32'd2);
      issue(4'd5, 32'd1, 32'd31);
      issue(4'd6, 32'h8000_0000, 32'd31);
      issue(4'd5, 32'hDEAD_BEEF, 32'd0);
      issue(4'd3, 32'd5, 32'd4);
      issue(4'd3, 32'hFFFF_FFFB, 32'hFFFF_FFBA);
      issue(4'd2, 32'hFFFF_FFD3, 32'hFFFF_FFEC);
      issue(4'd2, 32'd100, 32'h7FFF_FFFD);
      issue(4'd2, 32'hFFFF_FFFF, 32'd1);
      issue(4'd3, 32'h8000_0000, 32'd1);
      issue(4'd8, 32'hFFFF_FFF1, 32'hFFFF_FFF9);
      issue(4'd7, 32'd1024, 32'd2133);
      issue(4'd9, 32'd3024, 32'd2133);
      issue(4'd7, 32'hFFFF_FFFF, 32'd1);
      issue(4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(4'd10, 32'h8000_0000, 32'd4);
      issue(4'd11, 32'd77, 32'd77);
      issue(4'd12, 32'd77, 32'd77);
      idle(3);
      issue(4'd2, 32'd10, 32'd20);
      reset_with_valid();
      idle(2);
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(3) == 0) begin
            idle(1);
         end else begin
            ra = $urandom;
            rb = ($urandom_range(4) == 0) ? ra : $urandom;
            issue(4'($urandom_range(15)), ra, rb);
         end
      end
      idle(3);
      check_val("sb_drain", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
